cic_comp_fir: RTL and testbench

Decimating FIR that sits directly downstream of the CIC decimator in the receive chain. It consumes the CIC's 12-bit output samples, qualified by the CIC's output strobe clock, and compensates the CIC passband droop. It decimates by a further factor and emits 12-bit samples with a one-cycle valid pulse to the demodulator. A single shared multiplier runs a time-multiplexed multiply-accumulate (MAC) across all taps, using the clk cycles available between CIC output samples.

---
 rtl/cic_comp_pkg.sv | 19 +
 rtl/cic_comp_coeff_rom.sv | 17 +
 rtl/cic_comp_fir.sv | 169 ++++++++++++++++
 tb/tb_cic_comp_fir.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cic_comp_pkg.sv
// Shared types and helpers for the CIC droop-compensation decimating FIR.
package cic_comp_pkg;

  typedef enum logic [1:0] {CLEAR, IDLE, MAC, OUT} state_t;

  // Register stages between read issue and accumulate (read reg, multiply reg, acc).
  localparam int PIPE_LAT = 3;

  function automatic logic signed [63:0] sat(input logic signed [63:0] acc, input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (acc > hi)      return hi;
    else if (acc < lo) return lo;
    else               return acc;
  endfunction

endpackage

// File: rtl/cic_comp_coeff_rom.sv
// Synchronous-read coefficient ROM. Contents come from a packed parameter
// (c[0] in the LSBs) so the table elaborates without any file access.
module cic_comp_coeff_rom #(
  parameter int TAPS        = 32,
  parameter int COEFF_WIDTH = 16,
  parameter logic [TAPS*COEFF_WIDTH-1:0] COEFF_INIT = '0
) (
  input  logic                          clk,
  input  logic [$clog2(TAPS)-1:0]       addr,
  output logic signed [COEFF_WIDTH-1:0] coef
);

  always_ff @(posedge clk) begin
    coef <= COEFF_INIT[int'(addr)*COEFF_WIDTH +: COEFF_WIDTH];
  end

endmodule

// File: rtl/cic_comp_fir.sv
// Decimating CIC-compensation FIR: one shared multiplier runs a serial MAC over
// all taps between CIC output strobes.
//
// state | meaning
// CLEAR | zero one buffer entry per cycle after reset
// IDLE  | accept samples, count decimation phase
// MAC   | issue TAPS reads, then drain the pipeline
// OUT   | result registered, data_valid high; back to IDLE
module cic_comp_fir
  import cic_comp_pkg::*;
#(
  parameter int DATA_WIDTH     = 12,
  parameter int COEFF_WIDTH    = 16,
  parameter int TAPS           = 32,
  parameter int ACC_WIDTH      = 40,
  parameter int FIR_DECIMATION = 2,
  parameter int SHIFT          = 15,
  parameter logic [TAPS*COEFF_WIDTH-1:0] COEFF_INIT = (TAPS*COEFF_WIDTH)'(1) << (COEFF_WIDTH - 2)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  input  logic                         data_clk,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic                         data_valid,
  output logic                         busy,
  output logic                         overrun
);

  localparam int PW  = $clog2(TAPS);
  localparam int CW  = $clog2(TAPS + PIPE_LAT);
  localparam int PHW = (FIR_DECIMATION > 1) ? $clog2(FIR_DECIMATION) : 1;
  localparam logic [CW-1:0]  CLR_LAST = CW'(TAPS - 1);
  localparam logic [CW-1:0]  RD_END   = CW'(TAPS);
  localparam logic [CW-1:0]  MAC_LAST = CW'(TAPS + PIPE_LAT - 1);
  localparam logic [PHW-1:0] PH_LAST  = PHW'(FIR_DECIMATION - 1);
  localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [ACC_WIDTH-1:0] RND = (SHIFT > 0) ? (ACC_WIDTH'(1) << RND_POS) : '0;

  state_t                              state;
  logic [CW-1:0]                       cnt;
  logic [PW-1:0]                       wr_ptr;
  logic [PW-1:0]                       rd_addr;
  logic [PHW-1:0]                      phase;
  logic                                data_clk_q;
  logic                                evt;
  logic signed [DATA_WIDTH-1:0]        samp_buf [TAPS];
  logic signed [DATA_WIDTH-1:0]        samp_q;
  logic signed [COEFF_WIDTH-1:0]       coef_q;
  logic signed [COEFF_WIDTH+DATA_WIDTH-1:0] mul_q;
  logic signed [ACC_WIDTH-1:0]         acc;
  logic signed [ACC_WIDTH-1:0]         acc_rnd;
  logic signed [ACC_WIDTH-1:0]         res;
  logic signed [DATA_WIDTH-1:0]        out_sat;
  logic                                rd_vld;
  logic                                mul_vld;
  logic                                buf_we;
  logic [PW-1:0]                       buf_waddr;
  logic signed [DATA_WIDTH-1:0]        buf_wdata;

  assign evt = data_clk & ~data_clk_q;
  // Newest sample sits just below wr_ptr and pairs with c[0].
  assign rd_addr = wr_ptr - PW'(1) - cnt[PW-1:0];

  always_comb begin
    acc_rnd = acc + RND;
    res     = acc_rnd >>> SHIFT;
    out_sat = DATA_WIDTH'(sat(64'(res), DATA_WIDTH));
  end

  always_comb begin
    buf_we    = 1'b0;
    buf_waddr = wr_ptr;
    buf_wdata = data_in;
    if (!rst) begin
      if (state == CLEAR) begin
        buf_we    = 1'b1;
        buf_waddr = cnt[PW-1:0];
        buf_wdata = '0;
      end else if (state == IDLE && evt) begin
        buf_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) samp_buf[buf_waddr] <= buf_wdata;
  end

  cic_comp_coeff_rom #(
    .TAPS        (TAPS),
    .COEFF_WIDTH (COEFF_WIDTH),
    .COEFF_INIT  (COEFF_INIT)
  ) u_rom (
    .clk  (clk),
    .addr (cnt[PW-1:0]),
    .coef (coef_q)
  );

  always_ff @(posedge clk) begin
    samp_q <= samp_buf[rd_addr];
    mul_q  <= coef_q * samp_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CLEAR;
      cnt        <= '0;
      wr_ptr     <= '0;
      phase      <= '0;
      data_clk_q <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b1;
      overrun    <= 1'b0;
      acc        <= '0;
      rd_vld     <= 1'b0;
      mul_vld    <= 1'b0;
    end else begin
      data_clk_q <= data_clk;
      data_valid <= 1'b0;
      rd_vld     <= (state == MAC) && (cnt < RD_END);
      mul_vld    <= rd_vld;
      if (mul_vld) acc <= acc + ACC_WIDTH'(mul_q);
      case (state)
        CLEAR: begin
          if (cnt == CLR_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        IDLE: begin
          if (evt) begin
            wr_ptr <= wr_ptr + PW'(1);
            if (phase == PH_LAST) begin
              phase <= '0;
              state <= MAC;
              busy  <= 1'b1;
              cnt   <= '0;
              acc   <= '0;
            end else begin
              phase <= phase + PHW'(1);
            end
          end
        end
        MAC: begin
          if (evt) overrun <= 1'b1;
          if (cnt == MAC_LAST) begin
            data_out   <= out_sat;
            data_valid <= 1'b1;
            state      <= OUT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        OUT: begin
          if (evt) overrun <= 1'b1;
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_cic_comp_fir.sv
// Directed bench for cic_comp_fir: three instances with different coefficient
// sets cover impulse/latency, DC gain with rounding, saturation and control cases.
module tb_cic_comp_fir;

  localparam int TAPS = 32;
  localparam int CWD  = 16;

  function automatic logic [TAPS*CWD-1:0] ramp_coeffs();
    logic [TAPS*CWD-1:0] v;
    v = '0;
    for (int k = 0; k < TAPS; k++) v[k*CWD +: CWD] = CWD'(k + 1);
    return v;
  endfunction

  function automatic logic [TAPS*CWD-1:0] flat_coeffs(input int c);
    logic [TAPS*CWD-1:0] v;
    v = '0;
    for (int k = 0; k < TAPS; k++) v[k*CWD +: CWD] = CWD'(c);
    return v;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst  [3];
  logic               dclk [3];
  logic signed [11:0] din  [3];
  logic signed [11:0] dout [3];
  logic               dval [3];
  logic               busy [3];
  logic               ovr  [3];

  int n_checks = 0;
  int n_err    = 0;

  cic_comp_fir #(.FIR_DECIMATION(1), .SHIFT(0), .COEFF_INIT(ramp_coeffs())) u_imp (
    .clk(clk), .rst(rst[0]), .data_in(din[0]), .data_clk(dclk[0]),
    .data_out(dout[0]), .data_valid(dval[0]), .busy(busy[0]), .overrun(ovr[0]));

  cic_comp_fir #(.FIR_DECIMATION(2), .SHIFT(15), .COEFF_INIT(flat_coeffs(1024))) u_dc (
    .clk(clk), .rst(rst[1]), .data_in(din[1]), .data_clk(dclk[1]),
    .data_out(dout[1]), .data_valid(dval[1]), .busy(busy[1]), .overrun(ovr[1]));

  cic_comp_fir #(.FIR_DECIMATION(1), .SHIFT(15), .COEFF_INIT(flat_coeffs(2048))) u_sat (
    .clk(clk), .rst(rst[2]), .data_in(din[2]), .data_clk(dclk[2]),
    .data_out(dout[2]), .data_valid(dval[2]), .busy(busy[2]), .overrun(ovr[2]));

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_clear(input int u, input string tag);
    int n  = 0;
    int nv = 0;
    while (busy[u] && n < 100) begin
      tick();
      n++;
      if (dval[u]) nv++;
    end
    check({tag, "_busy_len"}, n, TAPS);
    check({tag, "_no_valid"}, nv, 0);
  endtask

  task automatic do_reset(input int u, input string tag);
    rst[u] = 1'b1;
    tick();
    tick();
    check({tag, "_rst_dout"}, int'(dout[u]), 0);
    check({tag, "_rst_valid"}, int'(dval[u]), 0);
    check({tag, "_rst_ovr"}, int'(ovr[u]), 0);
    check({tag, "_rst_busy"}, int'(busy[u]), 1);
    rst[u] = 1'b0;
    wait_clear(u, tag);
  endtask

  // One input event, then watch TAPS+6 cycles for the resulting output (if any).
  task automatic send(input int u, input int x, input bit exp_v, input bit chk_val,
                      input int exp_val, input int intr_at, input int intr_val,
                      input string tag);
    int lat = 0;
    int nv  = 0;
    int v   = 0;
    din[u]  = 12'(x);
    dclk[u] = 1'b1;
    for (int t = 1; t <= TAPS + 6; t++) begin
      tick();
      if (t == 1) dclk[u] = 1'b0;
      if (intr_at != 0 && t == intr_at) begin
        din[u]  = 12'(intr_val);
        dclk[u] = 1'b1;
      end
      if (intr_at != 0 && t == intr_at + 1) dclk[u] = 1'b0;
      if (dval[u]) begin
        nv++;
        if (lat == 0) begin
          lat = t;
          v   = int'(dout[u]);
        end
      end
    end
    check({tag, "_nvalid"}, nv, exp_v ? 1 : 0);
    if (exp_v) check({tag, "_latency"}, lat, TAPS + 4);
    if (chk_val) check({tag, "_value"}, v, exp_val);
  endtask

  initial begin
    for (int u = 0; u < 3; u++) begin
      rst[u]  = 1'b1;
      dclk[u] = 1'b0;
      din[u]  = '0;
    end
    tick();

    // Impulse response through the ramp filter c[k]=k+1, SHIFT=0.
    do_reset(0, "imp");
    send(0, 1, 1, 1, 1, 0, 0, "imp_0");
    for (int i = 0; i < 40; i++)
      send(0, 0, 1, 1, (i < 31) ? i + 2 : 0, 0, 0, $sformatf("imp_%0d", i + 1));

    // data_clk held high for 200 cycles: a single event.
    begin
      int nv = 0;
      int v  = 0;
      din[0]  = 12'sd9;
      dclk[0] = 1'b1;
      for (int t = 0; t < 200; t++) begin
        tick();
        if (dval[0]) begin
          nv++;
          v = int'(dout[0]);
        end
      end
      dclk[0] = 1'b0;
      tick();
      check("long_hi_nvalid", nv, 1);
      check("long_hi_value", v, 9);
      check("long_hi_ovr", int'(ovr[0]), 0);
    end

    // Overrun: second event 10 cycles into MAC is dropped; buffer holds [5,9].
    send(0, 5, 1, 1, 23, 10, 100, "ovr_a");
    check("ovr_set", int'(ovr[0]), 1);
    send(0, 0, 1, 1, 37, 0, 0, "ovr_b");
    check("ovr_sticky", int'(ovr[0]), 1);

    // Reset at E+10 abandons the MAC and wipes the buffer.
    begin
      int nv = 0;
      din[0]  = 12'sd7;
      dclk[0] = 1'b1;
      for (int t = 1; t <= 10; t++) begin
        tick();
        if (t == 1) dclk[0] = 1'b0;
        if (dval[0]) nv++;
      end
      rst[0] = 1'b1;
      tick();
      rst[0] = 1'b0;
      check("midmac_no_valid", nv + int'(dval[0]), 0);
      check("midmac_busy", int'(busy[0]), 1);
      wait_clear(0, "midmac");
      check("midmac_ovr_cleared", int'(ovr[0]), 0);
      send(0, 3, 1, 1, 3, 0, 0, "midmac_after");
    end

    // Rounding with c=1024, SHIFT=15, decimate by 2.
    do_reset(1, "rnd");
    send(1, 48, 0, 0, 0, 0, 0, "rnd_a0");
    send(1, 0, 1, 1, 2, 0, 0, "rnd_a1");
    send(1, -96, 0, 0, 0, 0, 0, "rnd_b0");
    send(1, 0, 1, 1, -1, 0, 0, "rnd_b1");

    // DC gain: constant 500, settled outputs equal 500.
    do_reset(1, "dc");
    for (int i = 1; i <= 36; i++)
      send(1, 500, (i % 2) == 0, (i >= 32) && (i % 2) == 0, 500, 0, 0, $sformatf("dc_%0d", i));

    // Saturation with c=2048.
    do_reset(2, "sat");
    for (int i = 1; i <= 32; i++)
      send(2, 2047, 1, (i == 8) || (i == 16) || (i == 32),
           (i == 8) ? 1024 : 2047, 0, 0, $sformatf("satp_%0d", i));
    for (int i = 1; i <= 32; i++)
      send(2, -2048, 1, i == 32, -2048, 0, 0, $sformatf("satn_%0d", i));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
